// File: rtl/cv32e40x_xif_result_scoreboard.sv
// XIF commit/result scoreboard: tracks issued IDs in order, records commit/kill,
// captures in-order FU results and releases only committed, non-killed ones.
module cv32e40x_xif_result_scoreboard #(
    parameter  int X_ID_WIDTH  = 4,
    parameter  int X_RFR_WIDTH = 32,
    parameter  int DEPTH       = 4,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [X_ID_WIDTH-1:0]  issue_id_i,
    input  logic [4:0]             issue_rd_i,
    input  logic                   commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]  commit_id_i,
    input  logic                   commit_kill_i,
    input  logic                   fu_valid_i,
    input  logic [X_ID_WIDTH-1:0]  fu_id_i,
    input  logic [X_RFR_WIDTH-1:0] fu_data_i,
    output logic                   fu_ready_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [X_ID_WIDTH-1:0]  result_id_o,
    output logic [4:0]             result_rd_o,
    output logic [X_RFR_WIDTH-1:0] result_data_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH-1:0]       r_done;
    logic [DEPTH-1:0]       r_cmt;
    logic [DEPTH-1:0]       r_kill;
    logic [X_ID_WIDTH-1:0]  r_id   [DEPTH];
    logic [4:0]             r_rd   [DEPTH];
    logic [X_RFR_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]       r_wr;
    logic [PTR_W-1:0]       r_fu;
    logic [PTR_W-1:0]       r_rdp;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;

    logic                   w_issue;
    logic                   w_fu;
    logic                   w_fin;
    logic                   w_pop;
    logic                   w_found;
    logic [DEPTH-1:0]       w_cmt_sel;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        issue_ready_o  = (r_cnt < DEPTH_C);
        fu_ready_o     = r_vld[r_fu] && !r_done[r_fu];
        w_issue        = issue_valid_i && issue_ready_o;
        w_fu           = fu_valid_i && fu_ready_o;
        w_fin          = r_vld[r_rdp] && r_done[r_rdp] && r_cmt[r_rdp];
        result_valid_o = w_fin && !r_kill[r_rdp];
        // Killed heads leave without a handshake
        w_pop          = w_fin && (r_kill[r_rdp] || result_ready_i);
        result_id_o    = r_id[r_rdp];
        result_rd_o    = r_rd[r_rdp];
        result_data_o  = r_data[r_rdp];
        count_o        = r_cnt;
        err_o          = r_err;
    end

    // First uncommitted live entry with a matching ID takes the commit
    always_comb begin
        w_cmt_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && !w_found && r_vld[i] && !r_cmt[i]
                && (r_id[i] == commit_id_i)) begin
                w_cmt_sel[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_done <= '0;
            r_cmt  <= '0;
            r_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]   <= '0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_wr  <= '0;
            r_fu  <= '0;
            r_rdp <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_vld[r_wr]  <= 1'b1;
                r_done[r_wr] <= 1'b0;
                r_cmt[r_wr]  <= 1'b0;
                r_kill[r_wr] <= 1'b0;
                r_id[r_wr]   <= issue_id_i;
                r_rd[r_wr]   <= issue_rd_i;
                r_wr         <= nxt(r_wr);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cmt_sel[i]) begin
                    r_cmt[i]  <= 1'b1;
                    r_kill[i] <= commit_kill_i;
                end
            end
            if (w_fu) begin
                r_data[r_fu] <= fu_data_i;
                r_done[r_fu] <= 1'b1;
                r_fu         <= nxt(r_fu);
            end
            if (w_pop) begin
                r_vld[r_rdp] <= 1'b0;
                r_rdp        <= nxt(r_rdp);
            end
            case ({w_issue, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if ((issue_valid_i && !issue_ready_o)
                || (w_fu && (fu_id_i != r_id[r_fu]))) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
